// File: rtl/steer_en_dp_if.sv
// Load-cell sample bus from the A2D front end into the steering-enable datapath.
interface steer_en_dp_if;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        vld;

    modport master (output lft_ld, rght_ld, vld);
    modport slave  (input  lft_ld, rght_ld, vld);
endinterface

// File: rtl/steer_en_dp.sv
// Steering-enable datapath: 4-sample load-cell averaging, weight/imbalance
// qualifiers, and the saturating settle timer used by the enable FSM.
module steer_en_dp #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h200,
    parameter logic [12:0] HYST         = 13'h040,
    parameter bit          FAST_SIM     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    steer_en_dp_if.slave  ld_bus,
    input  logic          clr_tmr,
    output logic          sum_gt_min,
    output logic          sum_lt_min,
    output logic          diff_gt_1_4,
    output logic          diff_gt_15_16,
    output logic          tmr_full
);

    localparam logic [12:0] THR_HI  = MIN_RIDER_WT + HYST;
    localparam logic [12:0] THR_LO  = MIN_RIDER_WT - HYST;
    localparam logic [25:0] TMR_CNT = FAST_SIM ? 26'd32768 : 26'd65_000_000;

    logic [11:0] lft_hist  [4];
    logic [11:0] rght_hist [4];
    logic [25:0] tmr_cnt;

    logic [13:0] lft_acc, rght_acc;
    logic [11:0] lft_avg, rght_avg;
    logic [12:0] sum, diff;
    logic [12:0] sum_q4, sum_15_16;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lft_hist[i]  <= '0;
                rght_hist[i] <= '0;
            end
        end else if (ld_bus.vld) begin
            lft_hist[0]  <= ld_bus.lft_ld;
            rght_hist[0] <= ld_bus.rght_ld;
            for (int i = 1; i < 4; i++) begin
                lft_hist[i]  <= lft_hist[i-1];
                rght_hist[i] <= rght_hist[i-1];
            end
        end
    end

    always_comb begin
        lft_acc  = 14'({2'b00, lft_hist[0]}) + 14'({2'b00, lft_hist[1]})
                 + 14'({2'b00, lft_hist[2]}) + 14'({2'b00, lft_hist[3]});
        rght_acc = 14'({2'b00, rght_hist[0]}) + 14'({2'b00, rght_hist[1]})
                 + 14'({2'b00, rght_hist[2]}) + 14'({2'b00, rght_hist[3]});
        lft_avg  = lft_acc[13:2];
        rght_avg = rght_acc[13:2];
        sum      = {1'b0, lft_avg} + {1'b0, rght_avg};
        diff     = (lft_avg >= rght_avg) ? {1'b0, lft_avg - rght_avg}
                                         : {1'b0, rght_avg - lft_avg};
        sum_q4    = sum >> 2;
        sum_15_16 = sum - (sum >> 4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b1;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else begin
            sum_gt_min    <= (sum > THR_HI);
            sum_lt_min    <= (sum < THR_LO);
            diff_gt_1_4   <= (diff > sum_q4);
            diff_gt_15_16 <= (diff > sum_15_16);
        end
    end

    // Saturates at TMR_CNT so tmr_full stays asserted until the FSM clears it.
    always_ff @(posedge clk) begin
        if (rst || clr_tmr)
            tmr_cnt <= '0;
        else if (tmr_cnt < TMR_CNT)
            tmr_cnt <= tmr_cnt + 26'd1;
    end

    assign tmr_full = (tmr_cnt == TMR_CNT);

endmodule

// File: doc/steer_en_dp.md
Name: steer_en_dp

Overview:
Datapath and timer partner of the steering-enable state machine. It averages the left and right load-cell samples and produces the four hysteresis/imbalance qualifiers that the state machine consumes. It also owns the 1.3 s settle timer, which it clears on the state machine's clr_tmr and reports back as tmr_full. It sits between the A2D load-cell interface and the steering-enable state machine.

Parameters:
MIN_RIDER_WT, 13'h200, minimum rider weight, in units of summed averaged load-cell counts.
HYST, 13'h040, hysteresis half-band around MIN_RIDER_WT. Must be less than MIN_RIDER_WT.
FAST_SIM, 0, timer threshold select: 0 gives TMR_CNT = 65_000_000 (1.3 s at 50 MHz); 1 gives TMR_CNT = 32768.

Ports:
clk  input  1  50 MHz clock, all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
lft_ld  input  12  left load-cell sample, unsigned.
rght_ld  input  12  right load-cell sample, unsigned.
vld  input  1  single-cycle strobe: lft_ld/rght_ld hold a new sample pair.
clr_tmr  input  1  from state machine, clears the settle timer.
sum_gt_min  output  1  averaged sum > MIN_RIDER_WT+HYST.
sum_lt_min  output  1  averaged sum < MIN_RIDER_WT-HYST.
diff_gt_1_4  output  1  |averaged difference| > sum/4.
diff_gt_15_16  output  1  |averaged difference| > 15/16 of sum.
tmr_full  output  1  settle timer has reached TMR_CNT.

Behaviour:
- Reset (rst high at a clock edge) clears:
  - both 4-deep sample histories to 0;
  - timer count to 0;
  - outputs: sum_gt_min=0, sum_lt_min=1, diff_gt_1_4=0, diff_gt_15_16=0, tmr_full=0.
  - rst takes priority over vld and clr_tmr in the same cycle.
- Sample capture:
  - On an edge with vld=1, each channel shifts its new sample into a 4-entry history and drops the oldest.
  - vld=0 leaves the histories unchanged.
  - Back-to-back vld is legal; one sample pair is accepted per cycle.
- Averaging:
  - lft_avg = (sum of 4 lft entries)>>2 and rght_avg likewise. Each is 14-bit accumulation, floored, giving a 12-bit result.
  - After reset the history holds zeros, so the average ramps up over the first 4 samples. No valid gating.
- Arithmetic, all unsigned with no overflow:
  - sum = lft_avg + rght_avg, 13 bits.
  - diff = |lft_avg - rght_avg|, 12 bits, zero-extended to 13 bits.
- Qualifiers, registered, all compares strict:
  - sum_gt_min = sum > MIN_RIDER_WT+HYST.
  - sum_lt_min = sum < MIN_RIDER_WT-HYST.
  - Inside the band [MIN-HYST, MIN+HYST] both are 0. They are never both 1.
  - diff_gt_1_4 = diff > (sum>>2).
  - diff_gt_15_16 = diff > (sum - (sum>>4)).
  - With sum=0 and diff=0, both diff flags are 0.
- Latency: the history updates at the edge that samples vld (E0); the qualifier registers reflect the new history at E0+1. The registers update every cycle.
- Timer:
  - 26-bit count. Each edge: rst or clr_tmr sets it to 0; otherwise, if count < TMR_CNT, it increments; otherwise it holds (saturates).
  - tmr_full = (count == TMR_CNT), decoded from the registered count.
  - clr_tmr sampled at edge N gives count=0 after N; tmr_full first goes high after edge N+TMR_CNT and stays high until the next clr_tmr or rst.
  - clr_tmr held high keeps count at 0.
  - clr_tmr while full drops tmr_full after that edge.
- The timer is independent of vld and of the qualifiers.

Test Plan:
- Ramp: after rst, 4 vld with lft=rght=12'h180 -> on the edge after the 4th: sum=0x300, sum_gt_min=1, sum_lt_min=0, diff flags 0. After only 1 sample of 12'h400 (each avg 0x100), sum=0x200 gives both sum flags 0.
- Hysteresis boundary, history filled:
  - lft=0x100, rght=0x0C0 -> sum=0x1C0, sum_lt_min=0, sum_gt_min=0.
  - rght=0x0BF -> sum=0x1BF, sum_lt_min=1.
  - lft=0x140, rght=0x100 -> sum=0x240, sum_gt_min=0.
  - rght=0x101 -> sum=0x241, sum_gt_min=1.
- Imbalance, history filled:
  - lft=0x200, rght=0x100 -> diff_gt_1_4=1, diff_gt_15_16=0.
  - lft=0x300, rght=0x010 -> diff=0x2F0 > 0x2DF, so both diff flags =1.
  - Swap channels -> identical flags.
- Timer with FAST_SIM=1:
  - clr_tmr pulse at edge N -> tmr_full=0 through edge N+32767, =1 after N+32768, held for 100 more cycles.
  - clr_tmr pulse -> tmr_full=0 on the next cycle.
- Reset mid-operation:
  - With the histories full at 0x300 and tmr_full=1, assert rst for 1 cycle concurrently with vld -> all outputs at their reset values and the vld sample is discarded.
  - The next single vld of 0x400/0x400 gives sum=0x200, with both sum flags 0.
